gsim_param: RTL and testbench
=============================

GSIM_PARAM -- requirements
Module: gsim_param

Interface
REQ-001 Parameter N, default 16: number of unknowns (range 4..64).
REQ-002 Parameter B_W, default 16: signed integer width of b_in.
REQ-003 Parameter X_W, default 32: signed fixed-point width of x_out.
REQ-004 Parameter F, default 16: fractional bits of x (X_W-F integer bits).
REQ-005 Parameter IT_W, default 8: width of iteration-limit and iteration-count fields.
REQ-006 clk  input  1  sole clock; all state changes on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_en  input  1  b word valid.
REQ-009 b_in  input  B_W  signed right-hand-side word b_i, index 0 first.
REQ-010 iter_max  input  IT_W  maximum sweeps, sampled with the b_0 word.
REQ-011 in_ready  output  1  block accepts a b word this cycle.
REQ-012 out_valid  output  1  x_out holds a result word.
REQ-013 out_ready  input  1  downstream accepts x_out this cycle.
REQ-014 x_out  output  X_W  signed fixed-point x_i, index 0 first.
REQ-015 sweeps  output  IT_W  number of sweeps performed for the current result, stable in OUT.
REQ-016 converged  output  1  high in OUT if the run stopped early on a zero-change sweep.

Function
REQ-017 The block SHALL solve 20x_i -13(x_{i-1}+x_{i+1}) +6(x_{i-2}+x_{i+2}) -(x_{i-3}+x_{i+3}) = b_i, with out-of-range neighbours equal to 0.
REQ-018 States SHALL be IDLE, LOAD, ITER, OUT; reset enters IDLE.
REQ-019 A b word is accepted when in_en && in_ready; in_en while in_ready=0 SHALL be ignored.
REQ-020 in_ready SHALL be 1 in IDLE and LOAD, 0 in ITER and OUT.
REQ-021 IDLE->LOAD on acceptance of b_0: all x registers cleared to 0, iter_max latched, value 0 treated as 1.
REQ-022 LOAD->ITER the cycle after the Nth word is accepted; gaps in in_en are allowed.
REQ-023 b_i SHALL be stored as sign-extended b_in shifted left by F bits.
REQ-024 ITER SHALL update exactly one unknown per cycle, index 0..N-1 per sweep, writing x_i at the end of that cycle so later indices use new values (strict Gauss-Seidel).
REQ-025 Update: S = b_i + 13(x_{i-1}+x_{i+1}) - 6(x_{i-2}+x_{i+2}) + (x_{i-3}+x_{i+3}), computed in X_W+6 bits without overflow; x_i = floor(S/20) exactly (round toward minus infinity), truncated to X_W bits.
REQ-026 A sweep takes exactly N cycles; sweeps increments at the end of each sweep.
REQ-027 ITER->OUT at the end of a sweep when sweeps equals the latched limit, or when no x_i changed during that sweep (converged=1 in the latter case only).
REQ-028 OUT SHALL present x_0..x_{N-1} in order; out_valid rises the cycle after the final ITER write.
REQ-029 x_out and out_valid SHALL hold stable while out_valid && !out_ready; the index advances only on out_valid && out_ready.
REQ-030 After x_{N-1} is accepted, the block SHALL enter IDLE the next cycle with out_valid=0.
REQ-031 out_valid SHALL be 0 in every state other than OUT.

Reset
REQ-032 reset=1 SHALL force IDLE, in_ready=1, out_valid=0, x_out=0, sweeps=0, converged=0 at the next edge, from any state, including mid-LOAD, mid-ITER and mid-OUT; partial data is discarded.
REQ-033 reset SHALL take priority over in_en and out_ready in the same cycle.

Verification
REQ-034 Zero case: N=16, all b=0, iter_max=5, out_ready=1 -> 16 words 0x00000000, sweeps=1, converged=1.
REQ-035 Single sweep: b_0=20, others 0, iter_max=1 -> x_0=0x00010000, x_1=0x0000A666, sweeps=1, converged=0.
REQ-036 Negative floor: b_0=-20 (0xFFEC), others 0, iter_max=1 -> x_0=0xFFFF0000, x_1=0xFFFF5999.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles in OUT -> x_out stays equal to x_0, out_valid stays 1; then all 16 words are delivered in order with no loss or duplication.
REQ-038 Reset mid-ITER: assert reset during sweep 2 -> IDLE next cycle with outputs per REQ-032; then a fresh load with b_0=20, iter_max=1 reproduces REQ-035 exactly.
REQ-039 Limit/latency: random b, iter_max=50 -> results match a bit-exact reference model; out_valid rises exactly 16*sweeps+1 cycles after entering ITER.

Source files
------------

// File: rtl/gsim_param.sv
// Gauss-Seidel solver for the banded system
//   20x_i - 13(x_{i-1}+x_{i+1}) + 6(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) = b_i.
// The b vector streams in, the solver sweeps one unknown per cycle, and then
// the signed fixed-point result streams out under ready/valid handshake.
module gsim_param #(
  parameter int N    = 16,
  parameter int B_W  = 16,
  parameter int X_W  = 32,
  parameter int F    = 16,
  parameter int IT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  input  logic [B_W-1:0]   b_in,
  input  logic [IT_W-1:0]  iter_max,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   x_out,
  output logic [IT_W-1:0]  sweeps,
  output logic             converged
);

  localparam int IDX_W = $clog2(N);
  // Six guard bits cover |13*2 + 6*2 + 2| * max|x| plus b without overflow.
  localparam int S_W   = X_W + 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [S_W-1:0] C6  = 6;
  localparam logic signed [S_W-1:0] C13 = 13;
  localparam logic signed [S_W-1:0] C20 = 20;

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic [IT_W-1:0]        limit;
  logic                   changed;
  logic signed [X_W-1:0]  x_mem [N];
  logic signed [X_W-1:0]  b_mem [N];

  logic                   accept;
  logic signed [X_W-1:0]  b_scaled;
  logic signed [S_W-1:0]  xm1, xp1, xm2, xp2, xm3, xp3;
  logic signed [S_W-1:0]  s_sum;
  logic signed [X_W-1:0]  x_new;
  logic                   changed_any;
  logic                   last_idx;
  logic [IT_W-1:0]        sweeps_inc;

  function automatic logic signed [S_W-1:0] sext(input logic signed [X_W-1:0] v);
    return {{(S_W-X_W){v[X_W-1]}}, v};
  endfunction

  // Division truncates toward zero; a negative remainder means the
  // quotient must step down by one to give the floor.
  function automatic logic signed [X_W-1:0] floor_div20(input logic signed [S_W-1:0] s);
    logic signed [S_W-1:0] q;
    logic signed [S_W-1:0] r;
    q = s / C20;
    r = s - q * C20;
    if (r < 0) q = q - 1;
    return q[X_W-1:0];
  endfunction

  assign in_ready   = (state == S_IDLE) || (state == S_LOAD);
  assign out_valid  = (state == S_OUT);
  assign accept     = in_en && in_ready;
  assign x_out      = (state == S_OUT) ? x_mem[idx] : '0;
  assign last_idx   = (idx == IDX_W'(N-1));
  assign sweeps_inc = sweeps + IT_W'(1);
  assign b_scaled   = {{(X_W-B_W){b_in[B_W-1]}}, b_in} << F;

  // Select the six neighbours of the current index; out-of-range ones read as 0.
  always_comb begin
    xm1 = '0; xp1 = '0; xm2 = '0; xp2 = '0; xm3 = '0; xp3 = '0;
    for (int j = 0; j < N; j++) begin
      if (j == int'(idx) - 1) xm1 = sext(x_mem[j]);
      if (j == int'(idx) + 1) xp1 = sext(x_mem[j]);
      if (j == int'(idx) - 2) xm2 = sext(x_mem[j]);
      if (j == int'(idx) + 2) xp2 = sext(x_mem[j]);
      if (j == int'(idx) - 3) xm3 = sext(x_mem[j]);
      if (j == int'(idx) + 3) xp3 = sext(x_mem[j]);
    end
  end

  // Gauss-Seidel update of the current unknown.
  always_comb begin
    s_sum       = sext(b_mem[idx]) + C13 * (xm1 + xp1) - C6 * (xm2 + xp2) + (xm3 + xp3);
    x_new       = floor_div20(s_sum);
    changed_any = changed || (x_new != x_mem[idx]);
  end

  // Data storage: b capture during load, x clear on b_0, x write-back in ITER.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (accept && state == S_IDLE) begin
        for (int j = 0; j < N; j++) x_mem[j] <= '0;
        b_mem[0] <= b_scaled;
      end else if (accept && state == S_LOAD) begin
        b_mem[idx] <= b_scaled;
      end else if (state == S_ITER) begin
        x_mem[idx] <= x_new;
      end
    end
  end

  // Control: state machine, index, sweep counting and termination.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      limit     <= '0;
      changed   <= 1'b0;
      sweeps    <= '0;
      converged <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_LOAD;
            idx       <= IDX_W'(1);
            limit     <= (iter_max == '0) ? IT_W'(1) : iter_max;
            sweeps    <= '0;
            converged <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (last_idx) begin
              state   <= S_ITER;
              idx     <= '0;
              changed <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_ITER: begin
          if (last_idx) begin
            sweeps  <= sweeps_inc;
            idx     <= '0;
            changed <= 1'b0;
            if ((sweeps_inc == limit) || !changed_any) begin
              state     <= S_OUT;
              converged <= !changed_any;
            end
          end else begin
            idx     <= idx + IDX_W'(1);
            changed <= changed_any;
          end
        end
        default: begin
          if (out_ready) begin
            if (last_idx) begin
              state <= S_IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_param.sv
// Scoreboard bench for gsim_param: stimulus pushes expected result words,
// a negedge monitor pops and compares every word the DUT hands over.
module tb_gsim_param;
  localparam int N    = 16;
  localparam int B_W  = 16;
  localparam int X_W  = 32;
  localparam int F    = 16;
  localparam int IT_W = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_en;
  logic [B_W-1:0]  b_in;
  logic [IT_W-1:0] iter_max;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [X_W-1:0]  x_out;
  logic [IT_W-1:0] sweeps;
  logic            converged;

  gsim_param #(.N(N), .B_W(B_W), .X_W(X_W), .F(F), .IT_W(IT_W)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .iter_max(iter_max),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .sweeps(sweeps), .converged(converged)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    int          idx;
    int          sw;
    bit          cv;
  } exp_t;

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     bv[N];
  longint mx[N];
  int     msw;
  bit     mcv;
  int     lat;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic longint fdiv20(input longint s);
    if (s >= 0) return s / 20;
    return -((-s + 19) / 20);
  endfunction

  function automatic longint wrap32(input longint v);
    logic signed [31:0] t;
    t = v[31:0];
    return longint'(t);
  endfunction

  function automatic longint g(input int j);
    if (j < 0 || j >= N) return 0;
    return mx[j];
  endfunction

  // Bit-exact reference: strict Gauss-Seidel with floor division.
  task automatic run_model(input int itmax);
    int lim;
    bit ch;
    longint s, nx;
    lim = (itmax == 0) ? 1 : itmax;
    for (int i = 0; i < N; i++) mx[i] = 0;
    msw = 0;
    mcv = 0;
    forever begin
      ch = 0;
      for (int i = 0; i < N; i++) begin
        s  = longint'(bv[i]) * 65536 + 13 * (g(i-1) + g(i+1)) - 6 * (g(i-2) + g(i+2)) + (g(i-3) + g(i+3));
        nx = wrap32(fdiv20(s));
        if (nx != mx[i]) ch = 1;
        mx[i] = nx;
      end
      msw++;
      if (!ch) begin
        mcv = 1;
        break;
      end
      if (msw == lim) break;
    end
  endtask

  task automatic push_model();
    for (int i = 0; i < N; i++) begin
      logic [63:0] w;
      w = mx[i];
      sb.push_back('{x: w[31:0], idx: i, sw: msw, cv: mcv});
    end
  endtask

  task automatic send_block(input int itmax, input bit gaps);
    logic [31:0] iw;
    iw = itmax;
    for (int i = 0; i < N; i++) begin
      if (gaps && (i % 5 == 2)) begin
        in_en = 1'b0;
        @(posedge clk); #1;
      end
      in_en    = 1'b1;
      b_in     = bv[i][15:0];
      iter_max = iw[7:0];
      @(posedge clk); #1;
    end
    in_en = 1'b0;
  endtask

  // Cycle 1 is the first ITER cycle; returns the cycle in which out_valid is first seen.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 5000);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check({tag, "_words_left"}, sb.size(), 0);
    @(negedge clk);
    check({tag, "_idle_out_valid"}, out_valid, 0);
    check({tag, "_idle_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic hand_case_pos();
    for (int i = 0; i < N; i++) bv[i] = 0;
    bv[0] = 20;
    run_model(1);
    push_model();
    sb[0].x = 32'h00010000;
    sb[1].x = 32'h0000A666;
    for (int i = 0; i < N; i++) begin
      sb[i].sw = 1;
      sb[i].cv = 0;
    end
  endtask

  // Monitor: every handed-over word is compared against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h, required no word", x_out);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("x[%0d]", mon_e.idx), longint'(x_out), longint'(mon_e.x));
        if (mon_e.idx == 0) begin
          check("sweeps", longint'(sweeps), longint'(mon_e.sw));
          check("converged", longint'(converged), longint'(mon_e.cv));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_en     = 1'b0;
    b_in      = '0;
    iter_max  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_x_out", x_out, 0);
    check("rst_sweeps", sweeps, 0);
    check("rst_converged", converged, 0);
    @(posedge clk); #1;

    // All-zero b converges after one sweep.
    for (int i = 0; i < N; i++) begin
      bv[i] = 0;
      sb.push_back('{x: 32'h0, idx: i, sw: 1, cv: 1'b1});
    end
    send_block(5, 1'b0);
    wait_out(lat);
    check("zero_latency", lat, 17);
    drain("zero");

    // Single sweep, b_0 = 20; in_en held high during ITER must be ignored.
    hand_case_pos();
    send_block(1, 1'b0);
    in_en = 1'b1;
    b_in  = 16'h7FFF;
    wait_out(lat);
    in_en = 1'b0;
    check("single_latency", lat, 17);
    drain("single");

    // Negative floor with input gaps, b_0 = -20.
    for (int i = 0; i < N; i++) bv[i] = 0;
    bv[0] = -20;
    run_model(1);
    push_model();
    sb[0].x = 32'hFFFF0000;
    sb[1].x = 32'hFFFF5999;
    send_block(1, 1'b1);
    wait_out(lat);
    check("neg_latency", lat, 17);
    drain("neg");

    // Backpressure: out_ready low for 10 cycles in OUT.
    for (int i = 0; i < N; i++) bv[i] = (i * 37) % 23 - 11;
    run_model(3);
    push_model();
    out_ready = 1'b0;
    send_block(3, 1'b0);
    wait_out(lat);
    check("bp_latency", lat, 16 * msw + 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_x0", longint'(x_out), longint'(sb[0].x));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("bp");

    // Reset during sweep 2 discards the run.
    for (int i = 0; i < N; i++) bv[i] = 100 + i * 7;
    send_block(5, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("midrun_in_ready", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_x_out", x_out, 0);
    check("midrun_rst_sweeps", sweeps, 0);
    check("midrun_rst_converged", converged, 0);
    @(posedge clk); #1;
    hand_case_pos();
    send_block(1, 1'b0);
    wait_out(lat);
    check("after_rst_latency", lat, 17);
    drain("after_rst");

    // Random b, iter_max = 50, against the reference model.
    for (int i = 0; i < N; i++) bv[i] = int'($urandom_range(4000, 0)) - 2000;
    run_model(50);
    push_model();
    send_block(50, 1'b1);
    wait_out(lat);
    check("rand_latency", lat, 16 * msw + 1);
    drain("rand");

    // iter_max = 0 behaves as a single sweep.
    for (int i = 0; i < N; i++) bv[i] = int'($urandom_range(4000, 0)) - 2000;
    run_model(0);
    push_model();
    send_block(0, 1'b0);
    wait_out(lat);
    check("itmax0_latency", lat, 17);
    drain("itmax0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
